// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a start/done handshake.
// Logic and arithmetic ops finish in one cycle; SLL/SRL run through a serial one-bit-per-cycle shifter.
module alu_exec_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   zero_o
);

  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_LUI = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  shift_acc;
  logic [SHAMT_WIDTH-1:0] shift_cnt;
  logic                   shift_left;
  logic [DATA_WIDTH-1:0]  result_q;

  logic [DATA_WIDTH-1:0]  single_result;
  logic [DATA_WIDTH-1:0]  shift_next;
  logic                   is_shift_op;
  logic                   accept;

  assign accept      = start_i && (state != SHIFT);
  assign is_shift_op = (alu_operation_i == OP_SLL) || (alu_operation_i == OP_SRL);
  assign shift_next  = shift_left ? (shift_acc << 1) : (shift_acc >> 1);

  // Shift ops only reach this path with shamt = 0, where the result is B unchanged.
  always_comb begin
    single_result = '0;
    case (alu_operation_i)
      OP_SUB:  single_result = a_i - b_i;
      OP_OR:   single_result = a_i | b_i;
      OP_ADD:  single_result = a_i + b_i;
      OP_LUI:  single_result = {{(DATA_WIDTH-16){1'b0}}, b_i[15:0]} << 16;
      OP_SLL:  single_result = b_i;
      OP_SRL:  single_result = b_i;
      OP_AND:  single_result = a_i & b_i;
      OP_NOR:  single_result = ~(a_i | b_i);
      OP_SW:   single_result = a_i + b_i;
      default: single_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_acc  <= '0;
      shift_cnt  <= '0;
      shift_left <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state)
        SHIFT: begin
          shift_acc <= shift_next;
          shift_cnt <= shift_cnt - SHAMT_WIDTH'(1);
          if (shift_cnt == SHAMT_WIDTH'(1)) begin
            result_q <= shift_next;
            state    <= DONE;
          end
        end
        default: begin
          if (accept) begin
            if (is_shift_op && (shamt_i != '0)) begin
              shift_acc  <= b_i;
              shift_cnt  <= shamt_i;
              shift_left <= (alu_operation_i == OP_SLL);
              state      <= SHIFT;
            end else begin
              result_q <= single_result;
              state    <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy_o   = (state == SHIFT);
  assign done_o   = (state == DONE);
  assign result_o = result_q;
  assign zero_o   = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: handshake timing, op results,
// serial shift latency, start-while-busy and asynchronous reset abort.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [4:0]  shamt_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;

  int total_checks;
  int passed_checks;

  alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .shamt_i         (shamt_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .result_o        (result_o),
    .zero_o          (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh);
    start_i         = s;
    alu_operation_i = op;
    a_i             = a;
    b_i             = b;
    shamt_i         = sh;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Full port snapshot; the unit is sampled on the falling edge.
  task automatic checkAll(input string tag, input logic [31:0] res,
                          input logic z, input logic busy, input logic done);
    checkOutput({tag, ".result"}, result_o, res);
    checkOutput({tag, ".zero"}, {31'd0, zero_o}, {31'd0, z});
    checkOutput({tag, ".busy"}, {31'd0, busy_o}, {31'd0, busy});
    checkOutput({tag, ".done"}, {31'd0, done_o}, {31'd0, done});
  endtask

  // Counts falling-edge samples with busy high until done appears (bounded).
  task automatic countBusy(output int busy_cycles);
    busy_cycles = 0;
    while (busy_o === 1'b1 && busy_cycles < 64) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int busy_cycles;
    int done_seen;
    total_checks  = 0;
    passed_checks = 0;

    reset = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    checkAll("reset", 32'h0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkAll("idle", 32'h0, 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] back-to-back single-cycle ops");
    applyStimulus(1'b1, 4'd3, 32'hFFFF_FFFF, 32'h1, 5'd0);
    @(negedge clk);
    checkAll("b2b_add", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd1, 32'd5, 32'd7, 5'd0);
    @(negedge clk);
    checkAll("b2b_sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd8, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    checkAll("b2b_nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd4, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0);
    @(negedge clk);
    checkAll("b2b_lui", 32'h1234_0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd3, 32'd9, 32'd9, 5'd0);
    @(negedge clk);
    checkAll("b2b_hold", 32'h1234_0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] serial shifts");
    applyStimulus(1'b1, 4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 5'd31);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    checkAll("sll31_first", 32'h1234_0000, 1'b0, 1'b1, 1'b0);
    countBusy(busy_cycles);
    checkOutput("sll31_busy_cycles", busy_cycles, 32'd31);
    checkAll("sll31_done", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkAll("sll31_after", 32'h8000_0000, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 4'd6, 32'h0, 32'h8000_0000, 5'd4);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    countBusy(busy_cycles);
    checkOutput("srl4_busy_cycles", busy_cycles, 32'd4);
    checkAll("srl4_done", 32'h0800_0000, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 4'd5, 32'h0, 32'h0000_ABCD, 5'd0);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    checkAll("sll0_done", 32'h0000_ABCD, 1'b0, 1'b0, 1'b1);

    $display("[TB] start ignored while busy");
    applyStimulus(1'b1, 4'd5, 32'h0, 32'h0000_0003, 5'd3);
    @(negedge clk);
    checkAll("ign_busy1", 32'h0000_ABCD, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd3, 32'd1, 32'd1, 5'd0);
    @(negedge clk);
    checkAll("ign_busy2", 32'h0000_ABCD, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    checkAll("ign_busy3", 32'h0000_ABCD, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkAll("ign_done", 32'h0000_0018, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkAll("ign_after", 32'h0000_0018, 1'b0, 1'b0, 1'b0);

    $display("[TB] invalid, SW and logic codes");
    applyStimulus(1'b1, 4'd0, 32'd5, 32'd6, 5'd0);
    @(negedge clk);
    checkAll("op0", 32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd9, 32'h0000_1000, 32'h0000_0024, 5'd0);
    @(negedge clk);
    checkAll("op9_sw", 32'h0000_1024, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd15, 32'h1, 32'h2, 5'd0);
    @(negedge clk);
    checkAll("op15", 32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd2, 32'h0000_00F0, 32'h0000_000F, 5'd0);
    @(negedge clk);
    checkAll("op_or", 32'h0000_00FF, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd7, 32'h0000_00FF, 32'h0000_003C, 5'd0);
    @(negedge clk);
    checkAll("op_and", 32'h0000_003C, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);

    $display("[TB] reset mid-shift");
    applyStimulus(1'b1, 4'd6, 32'h0, 32'hFFFF_0000, 5'd20);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      checkAll("rst_busy", 32'h0000_003C, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1 checkAll("rst_abort", 32'h0, 1'b1, 1'b0, 1'b0);
    #1 reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done_o !== 1'b0 || busy_o !== 1'b0) done_seen++;
    end
    checkOutput("rst_no_late_done", done_seen, 32'd0);
    applyStimulus(1'b1, 4'd3, 32'd2, 32'd3, 5'd0);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    checkAll("rst_then_add", 32'd5, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
